// File: rtl/eaglesong_absorb_ctrl.sv
// Eaglesong sponge absorb sequencer: folds 256-bit message chunks into the rate words,
// drives an external permutation through start/done and presents words 0..7 as the digest.

module eaglesong_absorb_comb (
   input  logic [511:0] state_i,
   input  logic [255:0] input_val_i,
   input  logic [6:0]   input_len_i,
   input  logic [7:0]   absorb_round_num_i,
   output logic [511:0] state_o
);
   logic [31:0] acc;

   // Bytes shift in big-endian; the 0x06 delimiter lands right after the last byte and
   // nothing shifts in past it, so a partial word stays right-aligned.
   always_comb begin
      state_o = state_i;
      acc     = '0;
      for (int j = 0; j < 8; j++) begin
         acc = '0;
         for (int k = 0; k < 4; k++) begin
            if (7'(4*j+k) < input_len_i)
               acc = {acc[23:0], input_val_i[8*(4*j+k) +: 8]};
            else if (7'(4*j+k) == input_len_i)
               acc = {acc[23:0], 8'h06};
         end
         state_o[32*j +: 32] = (absorb_round_num_i == 8'd0) ? acc : (state_i[32*j +: 32] ^ acc);
      end
   end
endmodule

module eaglesong_absorb_ctrl (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         msg_valid_i,
   output logic         msg_ready_o,
   input  logic [255:0] msg_data_i,
   input  logic [6:0]   msg_len_bytes_i,
   input  logic         msg_last_i,
   output logic         perm_start_o,
   output logic [511:0] perm_state_out_o,
   input  logic         perm_done_i,
   input  logic [511:0] perm_state_in_i,
   output logic         digest_valid_o,
   input  logic         digest_ready_i,
   output logic [255:0] digest_o,
   output logic         err_o
);
   typedef enum logic [2:0] {S_IDLE, S_PERM_REQ, S_PERM_WAIT, S_PAD, S_DONE} state_e;

   state_e       fsm_q, fsm_d;
   logic [511:0] st_q, st_d;
   logic [511:0] absorbed;
   logic [7:0]   cnt_q, cnt_d;
   logic         last_q, last_d, last_full_q, last_full_d, pad_q, pad_d, err_q, err_d;
   logic         msg_ready_q, perm_start_q, digest_valid_q;
   logic         accept, legal;

   eaglesong_absorb_comb u_comb (
      .state_i           (st_q),
      .input_val_i       (msg_data_i),
      .input_len_i       (msg_len_bytes_i),
      .absorb_round_num_i(cnt_q),
      .state_o           (absorbed)
   );

   assign legal  = (msg_len_bytes_i >= 7'd1) && (msg_len_bytes_i <= 7'd32) &&
                   (msg_last_i || (msg_len_bytes_i == 7'd32));
   assign accept = msg_ready_q && msg_valid_i;

   always_comb begin
      fsm_d       = fsm_q;
      st_d        = st_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      last_full_d = last_full_q;
      pad_d       = pad_q;
      err_d       = err_q;
      case (fsm_q)
         S_IDLE: begin
            if (accept) begin
               if (legal) begin
                  st_d        = absorbed;
                  cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                  last_d      = msg_last_i;
                  last_full_d = msg_last_i && (msg_len_bytes_i == 7'd32);
                  fsm_d       = S_PERM_REQ;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_PERM_REQ: fsm_d = S_PERM_WAIT;
         S_PERM_WAIT: begin
            if (perm_done_i) begin
               st_d = perm_state_in_i;
               if (!last_q)                  fsm_d = S_IDLE;
               else if (last_full_q && !pad_q) fsm_d = S_PAD;
               else                          fsm_d = S_DONE;
            end
         end
         S_PAD: begin
            // A full last chunk leaves no room for the delimiter, so it opens a fresh block.
            st_d[31:0] = st_q[31:0] ^ 32'h0600_0000;
            pad_d      = 1'b1;
            fsm_d      = S_PERM_REQ;
         end
         S_DONE: begin
            if (digest_ready_i) begin
               st_d        = '0;
               cnt_d       = '0;
               last_d      = 1'b0;
               last_full_d = 1'b0;
               pad_d       = 1'b0;
               fsm_d       = S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q          <= S_IDLE;
         st_q           <= '0;
         cnt_q          <= '0;
         last_q         <= 1'b0;
         last_full_q    <= 1'b0;
         pad_q          <= 1'b0;
         err_q          <= 1'b0;
         msg_ready_q    <= 1'b0;
         perm_start_q   <= 1'b0;
         digest_valid_q <= 1'b0;
      end else begin
         fsm_q          <= fsm_d;
         st_q           <= st_d;
         cnt_q          <= cnt_d;
         last_q         <= last_d;
         last_full_q    <= last_full_d;
         pad_q          <= pad_d;
         err_q          <= err_d;
         msg_ready_q    <= (fsm_d == S_IDLE);
         perm_start_q   <= (fsm_d == S_PERM_REQ);
         digest_valid_q <= (fsm_d == S_DONE);
      end
   end

   assign msg_ready_o      = msg_ready_q;
   assign perm_start_o     = perm_start_q;
   assign digest_valid_o   = digest_valid_q;
   assign perm_state_out_o = st_q;
   assign err_o            = err_q;

   for (genvar i = 0; i < 8; i++) begin : g_dig
      assign digest_o[255-32*i -: 32] = st_q[32*i +: 32];
   end
endmodule

// File: tb/tb_eaglesong_absorb_ctrl.sv
// Randomized and directed bench for eaglesong_absorb_ctrl with a 3-cycle permutation stub.
module tb_eaglesong_absorb_ctrl;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         msg_valid = 1'b0;
   logic         msg_ready;
   logic [255:0] msg_data = '0;
   logic [6:0]   msg_len = '0;
   logic         msg_last = 1'b0;
   logic         perm_start;
   logic [511:0] perm_state_out;
   logic         perm_done = 1'b0;
   logic [511:0] perm_state_in = '0;
   logic         digest_valid;
   logic         digest_ready = 1'b0;
   logic [255:0] digest;
   logic         err;

   int total = 0, bad = 0;
   int mode = 0;
   int nstarts = 0;
   int stub_cnt = 0;
   logic [511:0] stub_st = '0;
   logic [511:0] ms = '0;
   int mcnt = 0;
   int chk_hello = 0;
   logic [255:0] last_dig, hello_dig;
   logic [255:0] cq_data[$];
   int           cq_len[$];

   always #5 clk = ~clk;

   eaglesong_absorb_ctrl dut (
      .clk_i(clk), .rst_i(rst), .msg_valid_i(msg_valid), .msg_ready_o(msg_ready),
      .msg_data_i(msg_data), .msg_len_bytes_i(msg_len), .msg_last_i(msg_last),
      .perm_start_o(perm_start), .perm_state_out_o(perm_state_out), .perm_done_i(perm_done),
      .perm_state_in_i(perm_state_in), .digest_valid_o(digest_valid),
      .digest_ready_i(digest_ready), .digest_o(digest), .err_o(err)
   );

   function automatic logic [511:0] perm_fn(input logic [511:0] s);
      logic [511:0] r;
      logic [31:0]  w;
      r = s;
      if (mode == 1) r[511:480] = s[511:480] ^ 32'h1;
      else if (mode == 2)
         for (int i = 0; i < 16; i++) begin
            w = s[32*i +: 32];
            r[32*i +: 32] = {w[30:0], w[31]} ^ (32'h9E3779B9 * 32'(i + 1));
         end
      return r;
   endfunction

   // Stub ignores reset on purpose so an aborted permutation still delivers a stray done.
   always @(posedge clk) begin
      perm_done <= 1'b0;
      if (stub_cnt > 0) begin
         stub_cnt <= stub_cnt - 1;
         if (stub_cnt == 1) begin
            perm_done     <= 1'b1;
            perm_state_in <= perm_fn(stub_st);
         end
      end
      if (perm_start) begin
         stub_cnt <= 3;
         stub_st  <= perm_state_out;
         nstarts  <= nstarts + 1;
      end
   end

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference absorb: each rate word is built by shifting message bytes in MSB-first,
   // then one delimiter byte at the end of the message; XOR in unless this is the first block.
   function automatic logic [511:0] absorb_ref(input logic [511:0] s, input logic [255:0] d,
                                               input int len, input int cnt);
      logic [511:0] r;
      logic [31:0]  v;
      r = s;
      for (int j = 0; j < 8; j++) begin
         v = 0;
         for (int k = 0; k < 4; k++) begin
            int p = 4*j + k;
            if (p < len)       v = (v << 8) | 32'(d[8*p +: 8]);
            else if (p == len) v = (v << 8) | 32'h6;
         end
         r[32*j +: 32] = (cnt == 0) ? v : (s[32*j +: 32] ^ v);
      end
      return r;
   endfunction

   function automatic logic [255:0] dig_of(input logic [511:0] s);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = s[32*i +: 32];
      return r;
   endfunction

   task automatic send_chunk(input logic [255:0] d, input int len, input bit last);
      int t = 0;
      @(negedge clk);
      msg_valid = 1'b1; msg_data = d; msg_len = 7'(len); msg_last = last;
      while (!msg_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      msg_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (perm_done !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) chk("done_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic run_msg(input int bp);
      int n0, exp_starts;
      bit last;
      n0 = nstarts;
      exp_starts = cq_len.size() + ((cq_len[cq_len.size()-1] == 32) ? 1 : 0);
      for (int c = 0; c < cq_len.size(); c++) begin
         last = (c == cq_len.size() - 1);
         ms = absorb_ref(ms, cq_data[c], cq_len[c], mcnt);
         if (mcnt < 255) mcnt++;
         send_chunk(cq_data[c], cq_len[c], last);
         chk("start_pulse", perm_start, 1);
         chk("absorb_state", perm_state_out, ms);
         if (last && chk_hello > 0) begin
            chk("hello_w0", perm_state_out[31:0],   32'h48656C6C);
            chk("hello_w1", perm_state_out[63:32],  32'h6F2C2077);
            chk("hello_w2", perm_state_out[95:64],  32'h6F726C64);
            chk("hello_w3", perm_state_out[127:96], 32'h00210A06);
            if (chk_hello > 1) chk("hello_upper_zero", perm_state_out[511:128], 0);
         end
         wait_done();
         ms = perm_fn(ms);
         if (!last) begin
            chk("ready_after_done", msg_ready, 1);
            chk("state_after_perm", perm_state_out, ms);
         end else if (cq_len[c] == 32) begin
            chk("pad_cycle_no_start", perm_start, 0);
            chk("pad_cycle_no_digest", digest_valid, 0);
            @(posedge clk); #1;
            ms[31:0] = ms[31:0] ^ 32'h06000000;
            chk("pad_start", perm_start, 1);
            chk("padded_state", perm_state_out, ms);
            wait_done();
            ms = perm_fn(ms);
         end
      end
      chk("digest_valid", digest_valid, 1);
      chk("digest", digest, dig_of(ms));
      chk("perm_state_at_digest", perm_state_out, ms);
      last_dig = digest;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", digest_valid, 1);
         chk("bp_digest", digest, dig_of(ms));
         chk("bp_ready_low", msg_ready, 0);
      end
      chk("start_count", nstarts - n0, exp_starts);
      @(negedge clk); digest_ready = 1'b1;
      @(posedge clk); #1; digest_ready = 1'b0;
      chk("handoff_valid_low", digest_valid, 0);
      chk("handoff_ready_high", msg_ready, 1);
      chk("handoff_state_clear", perm_state_out, 0);
      ms = '0; mcnt = 0;
      cq_data.delete(); cq_len.delete();
   endtask

   function automatic logic [255:0] hello_data();
      string s = "Hello, world!\n";
      logic [255:0] d = '0;
      for (int i = 0; i < s.len(); i++) d[8*i +: 8] = s[i];
      return d;
   endfunction

   function automatic logic [255:0] rand_data();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, msg_ready, 0);
      chk({tag, "_start"}, perm_start, 0);
      chk({tag, "_dvalid"}, digest_valid, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_state"}, perm_state_out, 0);
      chk({tag, "_digest"}, digest, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] d;
      int n, n0;
      // reset
      repeat (2) @(posedge clk);
      #1; check_reset_outputs("reset");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_reset", msg_ready, 1);

      // single short chunk
      mode = 0; chk_hello = 2;
      cq_data.push_back(hello_data()); cq_len.push_back(14);
      run_msg(0);
      hello_dig = last_dig;
      chk("hello_digest_w0", hello_dig[255:224], 32'h48656C6C);

      // two chunks, stub flips bit 0 of word 15
      mode = 1; chk_hello = 1;
      cq_data.push_back('0); cq_len.push_back(32);
      cq_data.push_back(hello_data()); cq_len.push_back(14);
      run_msg(0);
      chk("word15_two", perm_state_out, 0);
      chk_hello = 0;

      // full 32-byte last chunk
      mode = 0;
      d = rand_data();
      cq_data.push_back(d); cq_len.push_back(32);
      run_msg(0);
      chk("full_last_w0", last_dig[255:224], {d[7:0], d[15:8], d[23:16], d[31:24]} ^ 32'h06000000);

      // illegal chunks
      n0 = nstarts;
      send_chunk(rand_data(), 0, 1'b1);
      chk("illegal0_err", err, 1);
      chk("illegal0_ready", msg_ready, 1);
      chk("illegal0_nostart", perm_start, 0);
      send_chunk(rand_data(), 20, 1'b0);
      chk("illegal20_ready", msg_ready, 1);
      chk("illegal20_nostart", perm_start, 0);
      chk("illegal_state", perm_state_out, 0);
      repeat (5) @(posedge clk); #1;
      chk("illegal_no_starts", nstarts - n0, 0);
      chk("err_sticky", err, 1);
      cq_data.push_back(hello_data()); cq_len.push_back(14);
      run_msg(0);
      chk("after_illegal_digest", last_dig, hello_dig);

      // reset during PERM_WAIT, then stray done
      send_chunk(rand_data(), 32, 1'b0);
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midreset");
      @(negedge clk); rst = 1'b0;
      n0 = nstarts;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("stray_ready", msg_ready, 1);
         chk("stray_state", perm_state_out, 0);
         chk("stray_dvalid", digest_valid, 0);
      end
      chk("stray_no_start", nstarts - n0, 0);
      cq_data.push_back(hello_data()); cq_len.push_back(14);
      run_msg(0);
      chk("after_reset_digest", last_dig, hello_dig);

      // digest backpressure
      mode = 2;
      cq_data.push_back(rand_data()); cq_len.push_back(32);
      cq_data.push_back(rand_data()); cq_len.push_back(9);
      run_msg(10);

      // randomized messages
      for (int m = 0; m < 24; m++) begin
         n = $urandom_range(1, 4);
         for (int c = 0; c < n - 1; c++) begin
            cq_data.push_back(rand_data()); cq_len.push_back(32);
         end
         cq_data.push_back(rand_data()); cq_len.push_back($urandom_range(1, 32));
         run_msg($urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
